// File: rtl/pixel_histogram.sv
// pixel_histogram: 256-bin frame histogram of an 8-bit pixel stream.
//
// Every frame runs through three phases:
//   CLEAR   - zero all 256 bins, one per cycle
//   ACCUM   - count IMG_WIDTH*IMG_HEIGHT accepted pixels into the bins
//   READOUT - present bins 0..255 as a valid/ready stream, then return to CLEAR
//
// Ports:
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   pixel_in       8-bit pixel value, qualified by data_valid_in
//   data_valid_in  pixel qualifier; there is no backpressure to upstream
//   in_ready       high while pixels are being counted; pixels seen while low are dropped
//   hist_bin       bin index of the current readout word
//   hist_count     count for hist_bin (0 while hist_valid is low)
//   hist_valid     readout word valid
//   hist_ready     readout consumer accepts the word
//   hist_last      marks the word for bin 255
//   drop_flag      sticky: a pixel arrived while in_ready was low; cleared by rst
module pixel_histogram #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512,
    parameter int unsigned COUNT_W    = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pixel_in,
    input  logic               data_valid_in,
    output logic               in_ready,
    output logic [7:0]         hist_bin,
    output logic [COUNT_W-1:0] hist_count,
    output logic               hist_valid,
    input  logic               hist_ready,
    output logic               hist_last,
    output logic               drop_flag
);

    localparam int unsigned        TOTAL   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [COUNT_W-1:0] TOTAL_C = COUNT_W'(TOTAL);

    typedef enum logic [1:0] {StClear, StAccum, StReadout} state_e;

    state_e             state_q, state_d;
    logic [7:0]         clr_addr_q, clr_addr_d;
    logic [COUNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic [7:0]         s1_addr_q, s1_addr_d;
    logic               fwd_q, fwd_d;
    logic [COUNT_W-1:0] fwd_val_q, fwd_val_d;
    logic               hist_valid_q, hist_valid_d;
    logic [7:0]         hist_bin_q, hist_bin_d;
    logic               drop_q, drop_d;

    logic [COUNT_W-1:0] bins_mem [256];
    logic [COUNT_W-1:0] rdata_q;
    logic [7:0]         rd_addr;
    logic               we;
    logic [7:0]         wa;
    logic [COUNT_W-1:0] wd;
    logic               accept;
    logic [COUNT_W-1:0] rmw_cnt;

    assign in_ready   = (state_q == StAccum) && (pix_cnt_q != TOTAL_C);
    assign accept     = in_ready && data_valid_in;
    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign hist_count = hist_valid_q ? rdata_q : '0;
    assign hist_last  = hist_valid_q && (hist_bin_q == 8'hFF);
    assign drop_flag  = drop_q;

    // Second RMW stage: the read issued last cycle is stale if the previous pixel hit the
    // same bin, because that bin was written on the very edge the read was taken.
    assign rmw_cnt = (fwd_q ? fwd_val_q : rdata_q) + COUNT_W'(1);

    // Single shared read port: pixel bin in ACCUM, next/held word in READOUT.
    // Re-reading the held bin during a stall keeps hist_count stable (no writes in READOUT).
    always_comb begin
        rd_addr = pixel_in;
        if (state_q == StReadout) begin
            if (!hist_valid_q) begin
                rd_addr = 8'd0;
            end else if (hist_ready) begin
                rd_addr = hist_bin_q + 8'd1;
            end else begin
                rd_addr = hist_bin_q;
            end
        end
    end

    always_comb begin
        we = 1'b0;
        wa = clr_addr_q;
        wd = '0;
        if (s1_valid_q) begin
            we = 1'b1;
            wa = s1_addr_q;
            wd = rmw_cnt;
        end else if (state_q == StClear) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            bins_mem[wa] <= wd;
        end
        rdata_q <= bins_mem[rd_addr];
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        pix_cnt_d    = pix_cnt_q;
        s1_valid_d   = accept;
        s1_addr_d    = pixel_in;
        fwd_d        = accept && s1_valid_q && (pixel_in == s1_addr_q);
        fwd_val_d    = rmw_cnt;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        drop_d       = drop_q | (data_valid_in & ~in_ready);

        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + 8'd1;
                if (clr_addr_q == 8'hFF) begin
                    state_d   = StAccum;
                    pix_cnt_d = '0;
                end
            end
            StAccum: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + COUNT_W'(1);
                end
                // Leave only after the final write has landed in the RAM.
                if (pix_cnt_q == TOTAL_C && !s1_valid_q) begin
                    state_d = StReadout;
                end
            end
            StReadout: begin
                if (!hist_valid_q) begin
                    hist_valid_d = 1'b1;
                    hist_bin_d   = 8'd0;
                end else if (hist_ready) begin
                    if (hist_bin_q == 8'hFF) begin
                        hist_valid_d = 1'b0;
                        hist_bin_d   = 8'd0;
                        state_d      = StClear;
                        clr_addr_d   = 8'd0;
                        pix_cnt_d    = '0;
                    end else begin
                        hist_bin_d = hist_bin_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = StClear;
                clr_addr_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StClear;
            clr_addr_q   <= 8'd0;
            pix_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= 8'd0;
            fwd_q        <= 1'b0;
            fwd_val_q    <= '0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= 8'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            pix_cnt_q    <= pix_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            fwd_q        <= fwd_d;
            fwd_val_q    <= fwd_val_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_pixel_histogram.sv
// tb_pixel_histogram: directed + randomized frames on a 4x4 image, checked against a
// per-frame reference histogram built from the pixels the bench itself sends.
module tb_pixel_histogram;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pixel_in;
    logic          data_valid_in;
    logic          in_ready;
    logic [7:0]    hist_bin;
    logic [CW-1:0] hist_count;
    logic          hist_valid;
    logic          hist_ready;
    logic          hist_last;
    logic          drop_flag;

    always #5 clk = ~clk;

    pixel_histogram #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COUNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .data_valid_in(data_valid_in),
        .in_ready     (in_ready),
        .hist_bin     (hist_bin),
        .hist_count   (hist_count),
        .hist_valid   (hist_valid),
        .hist_ready   (hist_ready),
        .hist_last    (hist_last),
        .drop_flag    (drop_flag)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         ref_hist [256];
    logic [7:0] pix_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; counts clock cycles until in_ready rises.
    task automatic wait_ready(input int exp_cyc);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (in_ready !== 1'b1 && cyc < 600);
        chk("ready_latency", 32'(cyc), 32'(exp_cyc));
    endtask

    // gap_mode 0: back-to-back, 1: one idle cycle between pixels, 2: random idle cycles.
    task automatic feed(input int gap_mode);
        foreach (ref_hist[i]) ref_hist[i] = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            if (gap_mode == 1 && i > 0) begin
                data_valid_in = 1'b0;
                @(negedge clk);
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    data_valid_in = 1'b0;
                    @(negedge clk);
                end
            end
            chk("in_ready_accum", 32'(in_ready), 32'd1);
            pixel_in      = pix_q[i];
            data_valid_in = 1'b1;
            ref_hist[pix_q[i]]++;
            @(negedge clk);
        end
        data_valid_in = 1'b0;
        chk("in_ready_after_last", 32'(in_ready), 32'd0);
    endtask

    // rdy_mode 0: hist_ready always high, 1: random. stall_bin holds ready low 5 cycles on
    // that bin; drop_at injects a pixel while that bin is shown; abort_at resets there.
    task automatic readout(input int rdy_mode, input int stall_bin, input int drop_at,
                           input int abort_at);
        int   k     = 0;
        int   cyc   = 0;
        int   first = -1;
        int   stall = 0;
        logic rdy;
        while (k < 256 && cyc < 4000) begin
            data_valid_in = 1'b0;
            if (hist_valid === 1'b1) begin
                if (first < 0) first = cyc;
                if (k == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_valid", 32'(hist_valid), 32'd0);
                    chk("abort_count", 32'(hist_count), 32'd0);
                    chk("abort_bin", 32'(hist_bin), 32'd0);
                    chk("abort_last", 32'(hist_last), 32'd0);
                    chk("abort_in_ready", 32'(in_ready), 32'd0);
                    chk("abort_drop", 32'(drop_flag), 32'd0);
                    rst = 1'b0;
                    return;
                end
                chk("bin", 32'(hist_bin), 32'(k));
                chk("count", 32'(hist_count), 32'(ref_hist[k]));
                chk("last", 32'(hist_last), 32'(k == 255));
                if (k == drop_at) begin
                    data_valid_in = 1'b1;
                    pixel_in      = 8'h55;
                end
                rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (k == stall_bin && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end
                hist_ready = rdy;
                if (rdy) k++;
            end else begin
                chk("count_idle", 32'(hist_count), 32'd0);
                hist_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        data_valid_in = 1'b0;
        chk("words_accepted", 32'(k), 32'd256);
        chk("valid_after_last", 32'(hist_valid), 32'd0);
        chk("count_after_last", 32'(hist_count), 32'd0);
        chk("first_word_latency", 32'(first >= 0 && first <= 4), 32'd1);
        if (stall_bin >= 0) chk("stall_cycles", 32'(stall), 32'd5);
        if (rdy_mode == 0) chk("throughput", 32'(cyc - first), 32'd256);
    endtask

    task automatic fill_random();
        pix_q = {};
        for (int i = 0; i < int'(W * H); i++) begin
            if ($urandom_range(0, 1) == 1) pix_q.push_back(8'($urandom_range(0, 7)));
            else                           pix_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        data_valid_in = 1'b0;
        pixel_in      = 8'd0;
        hist_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(hist_valid), 32'd0);
        chk("rst_last", 32'(hist_last), 32'd0);
        chk("rst_bin", 32'(hist_bin), 32'd0);
        chk("rst_count", 32'(hist_count), 32'd0);
        chk("rst_drop", 32'(drop_flag), 32'd0);
        rst = 1'b0;
        wait_ready(256);
        chk("drop_after_clear", 32'(drop_flag), 32'd0);

        // Single bin gets the whole frame.
        pix_q = {};
        repeat (W * H) pix_q.push_back(8'h07);
        feed(0);
        readout(0, -1, -1, -1);
        wait_ready(256);

        // Distinct values on alternate cycles.
        pix_q = {};
        for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
        feed(1);
        readout(0, -1, -1, -1);
        wait_ready(256);

        // A,A,B,A repeated back-to-back exercises both forwarding paths.
        pix_q = {};
        repeat (4) begin
            pix_q.push_back(8'h10);
            pix_q.push_back(8'h10);
            pix_q.push_back(8'h20);
            pix_q.push_back(8'h10);
        end
        feed(0);
        chk("ref_bin10", 32'(ref_hist[8'h10]), 32'd12);
        chk("ref_bin20", 32'(ref_hist[8'h20]), 32'd4);
        readout(0, -1, -1, -1);
        wait_ready(256);

        // Random frame, random hist_ready with a stall on bin 3, pixel dropped in readout.
        fill_random();
        feed(2);
        readout(1, 3, 50, -1);
        chk("drop_set", 32'(drop_flag), 32'd1);
        wait_ready(256);
        chk("drop_sticky", 32'(drop_flag), 32'd1);

        // Random frame aborted by reset at bin 100.
        fill_random();
        feed(2);
        readout(1, -1, -1, 100);
        wait_ready(256);

        // Frame after the abort must read back clean counts.
        fill_random();
        feed(0);
        readout(1, -1, -1, -1);
        wait_ready(256);
        chk("drop_final", 32'(drop_flag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
